// File: rtl/rsa_word_loader_pkg.sv
// rsa_word_loader_pkg: shared widths and FSM state encoding for the RSA word loader
package rsa_word_loader_pkg;
  localparam int DEF_KEY_W = 2048;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_NW = DEF_KEY_W / DEF_WORD_W;
  localparam int DEF_CNT_W = $clog2(DEF_NW);
  typedef enum logic [2:0] {
    LOAD_N,
    LOAD_E,
    LOAD_C,
    KICK,
    RUN,
    ZERO_E,
    UNLOAD
  } state_t;
endpackage

// File: rtl/rsa_word_loader_if.sv
// rsa_word_loader_if: word-serial operand input stream and result output stream
interface rsa_word_loader_if
  import rsa_word_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/rsa_word_shift.sv
// rsa_word_shift: wide register with word-lane write, word-lane read and whole-register load
module rsa_word_shift
  import rsa_word_loader_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int WORD_W = DEF_WORD_W,
  localparam int CW = $clog2(KEY_W / WORD_W)
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              ld_en,
  input  logic [KEY_W-1:0]  ld_data,
  input  logic [CW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [KEY_W-1:0]  q
);
  assign rd_data = q[rd_idx*WORD_W +: WORD_W];
  // Whole-register load wins over a single-lane write
  always_ff @(posedge clk or posedge sys_rst)
    if (sys_rst) q <= '0;
    else if (ld_en) q <= ld_data;
    else if (wr_en) q[wr_idx*WORD_W +: WORD_W] <= wr_data;
endmodule

// File: rtl/rsa_word_loader.sv
// rsa_word_loader: loads n/e/c word-serially, sequences the modexp core, streams the result back
module rsa_word_loader
  import rsa_word_loader_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic               clk,
  input  logic               sys_rst,
  rsa_word_loader_if.slave   bus,
  output logic               busy,
  output logic [KEY_W-1:0]   core_n,
  output logic [KEY_W-1:0]   core_e,
  output logic [KEY_W-1:0]   core_c,
  output logic               core_rst,
  output logic               core_enable,
  input  logic               core_finish,
  input  logic [KEY_W-1:0]   core_result
);
  localparam int NW = KEY_W / WORD_W;
  localparam int CW = $clog2(NW);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              e_nz;
  logic              armed;
  logic              hs;
  logic              last_w;
  logic              res_ld;
  logic [CW-1:0]     rd_idx;
  logic [WORD_W-1:0] res_rd;
  logic [WORD_W-1:0] n_rd;
  logic [WORD_W-1:0] e_rd;
  logic [WORD_W-1:0] c_rd;
  logic [KEY_W-1:0]  res_q;
  logic [KEY_W-1:0]  res_src;
  logic              unused_ok;
  assign hs = bus.s_valid & bus.s_ready;
  assign last_w = cnt == CW'(NW - 1);
  assign res_ld = (state == RUN && armed && core_finish) || state == ZERO_E;
  assign res_src = state == ZERO_E ? KEY_W'(1) : core_result;
  assign rd_idx = bus.m_valid ? cnt + CW'(1) : cnt;
  assign unused_ok = ^{n_rd, e_rd, c_rd, res_q};
  rsa_word_shift #(.KEY_W(KEY_W), .WORD_W(WORD_W)) u_n (
    .clk(clk), .sys_rst(sys_rst), .wr_en(hs && state == LOAD_N), .wr_idx(cnt), .wr_data(bus.s_data),
    .ld_en(1'b0), .ld_data('0), .rd_idx(cnt), .rd_data(n_rd), .q(core_n)
  );
  rsa_word_shift #(.KEY_W(KEY_W), .WORD_W(WORD_W)) u_e (
    .clk(clk), .sys_rst(sys_rst), .wr_en(hs && state == LOAD_E), .wr_idx(cnt), .wr_data(bus.s_data),
    .ld_en(1'b0), .ld_data('0), .rd_idx(cnt), .rd_data(e_rd), .q(core_e)
  );
  rsa_word_shift #(.KEY_W(KEY_W), .WORD_W(WORD_W)) u_c (
    .clk(clk), .sys_rst(sys_rst), .wr_en(hs && state == LOAD_C), .wr_idx(cnt), .wr_data(bus.s_data),
    .ld_en(1'b0), .ld_data('0), .rd_idx(cnt), .rd_data(c_rd), .q(core_c)
  );
  rsa_word_shift #(.KEY_W(KEY_W), .WORD_W(WORD_W)) u_res (
    .clk(clk), .sys_rst(sys_rst), .wr_en(1'b0), .wr_idx(cnt), .wr_data('0),
    .ld_en(res_ld), .ld_data(res_src), .rd_idx(rd_idx), .rd_data(res_rd), .q(res_q)
  );
  // Job sequencer: operand load, core reset/enable handshake, result unload
  always_ff @(posedge clk or posedge sys_rst)
    if (sys_rst) begin
      state <= LOAD_N;
      cnt <= '0;
      e_nz <= 1'b0;
      armed <= 1'b0;
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      bus.m_last <= 1'b0;
      busy <= 1'b0;
      core_rst <= 1'b1;
      core_enable <= 1'b0;
    end else begin
      case (state)
        LOAD_N, LOAD_E, LOAD_C: begin
          bus.s_ready <= 1'b1;
          core_rst <= 1'b0;
          if (hs) begin
            busy <= 1'b1;
            cnt <= last_w ? '0 : cnt + CW'(1);
            if (state == LOAD_E) e_nz <= e_nz | (|bus.s_data);
            if (last_w) begin
              state <= state == LOAD_N ? LOAD_E : state == LOAD_E ? LOAD_C : e_nz ? KICK : ZERO_E;
              if (state == LOAD_N) e_nz <= 1'b0;
              if (state == LOAD_C) begin
                bus.s_ready <= 1'b0;
                core_rst <= e_nz;
              end
            end
          end
        end
        KICK: begin
          core_rst <= 1'b0;
          core_enable <= 1'b1;
          armed <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          armed <= 1'b1;
          if (armed && core_finish) begin
            core_enable <= 1'b0;
            state <= UNLOAD;
          end
        end
        ZERO_E: state <= UNLOAD;
        UNLOAD: begin
          if (!bus.m_valid) begin
            bus.m_valid <= 1'b1;
            bus.m_data <= res_rd;
            bus.m_last <= rd_idx == CW'(NW - 1);
          end else if (bus.m_ready) begin
            if (last_w) begin
              bus.m_valid <= 1'b0;
              bus.m_last <= 1'b0;
              busy <= 1'b0;
              cnt <= '0;
              bus.s_ready <= 1'b1;
              state <= LOAD_N;
            end else begin
              cnt <= cnt + CW'(1);
              bus.m_data <= res_rd;
              bus.m_last <= rd_idx == CW'(NW - 1);
            end
          end
        end
        default: state <= LOAD_N;
      endcase
    end
endmodule
